alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

EX-stage sequencer for the shared integer ALU in the 5-stage RISC-V pipeline. Accepts one decoded ALU instruction from ID/EX and translates opcode/funct3/funct7[5] into the ALU's 4-bit operation select. Drives the ALU operand buses and captures the ALU result. Executes shifts iteratively by looping shift-by-1 through the ALU, and raises `busy` so the hazard unit stalls IF/ID while a multi-cycle shift is in flight.

## Interface
- `XLEN`, 32: operand/result width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `in_valid`  in  1  ID/EX presents an operation.
- `in_ready`  out  1  sequencer can accept.
- `in_opcode`  in  7  instruction[6:0].
- `in_funct3`  in  3  instruction[14:12].
- `in_f7b5`  in  1  instruction[30].
- `in_a`  in  XLEN  rs1 value.
- `in_b`  in  XLEN  rs2 value or immediate; LUI immediate is pre-shifted by 12.
- `alu_sel`  out  4  ALU op: add 0, sub 1, lui 2, and 3, xor 4, or 5, sll 6, srl 7, sra 8, slt 9, sltu 10.
- `alu_a`, `alu_b`  out  XLEN  ALU operands.
- `alu_result`  in  XLEN  combinational ALU output.
- `out_valid`  out  1  `out_result` valid.
- `out_ready`  in  1  EX/MEM accepts the result.
- `out_result`  out  XLEN  registered result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The one clock and the asynchronous active-low reset are already decided.
- Decode for opcode 0110011 (R-type) and 0010011 (I-ALU), by funct3:
  - 000: add; sub only when R-type and f7b5=1.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when f7b5=1 (both types).
  - 110: or.
  - 111: and.
- Opcode 0110111 decodes to lui. Every other opcode decodes to add (address/link calculation).
- Accept occurs when `in_valid && in_ready`. On accept, the sequencer latches the decoded op, `in_a` into a partial register P, `in_b`, and the count `cnt = in_b[4:0]`.
- States:
  - IDLE: `in_ready`=1. `alu_sel`=0, `alu_a`=0, `alu_b`=0. On accept, a shift op with cnt≠0 goes to SHIFT; anything else goes to EXEC.
  - EXEC: drives the latched op, `alu_a`=P and `alu_b`=latched b. Captures `alu_result` into `out_result`, then goes to DONE.
  - SHIFT: drives the latched shift op, `alu_a`=P and `alu_b`=1. Each cycle it updates P←`alu_result` and decrements cnt. When cnt=1 it also loads `out_result`←`alu_result` and goes to DONE.
  - DONE: `out_valid`=1 and `out_result` is held. When `out_ready`=1 it goes to IDLE.
- `in_ready` is high only in IDLE, so there is no accept/drain overlap.
- Shift with amount 0 takes the EXEC path, which yields `in_a` unchanged.
- slt/sltu results arrive zero-extended from the ALU and pass through unmodified.
- `flush` has priority over every other transition. From any state it forces IDLE at the next edge and clears `out_valid`; `out_result` keeps its stale value. A `flush` in IDLE blocks that cycle's accept.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_result`=0, P=0, cnt=0, `busy`=0, `in_ready`=1, `alu_sel`/`alu_a`/`alu_b`=0.
- Latency counts edges from the accept edge to `out_valid` high:
  - Non-shift op: 1.
  - Shift by s≥1: s (iterative build).
  - Maximum is 31 cycles, for s=31.
- `out_valid` stays high with a stable result until `out_ready`. The earliest next accept is the cycle after the drain edge.
- Assertion of `rst_n` mid-shift aborts immediately (asynchronous); no partial result is ever presented.

## Configuration
- `ALU_FAST_SHIFT_EN` defined: every shift takes the EXEC path with `alu_b`=latched b. The external ALU shifter does the full amount in one cycle, so all latencies are 1. The SHIFT state and cnt logic are compiled out, and `busy` is high only in EXEC/DONE.
- `ALU_FAST_SHIFT_EN` undefined: iterative behaviour as specified above.

## Test plan
- Reset: hold `rst_n`=0 mid-operation, release → all outputs at reset values; `in_ready`=1 on the first cycle.
- R-type sub, a=5, b=7 → `alu_sel`=1 during EXEC; `out_result`=0xFFFFFFFE one cycle after accept; addi with f7b5=1 → `alu_sel`=0.
- srai a=0x80000000, b=4 → 4 SHIFT cycles with `alu_sel`=8 and `alu_b`=1; `out_result`=0xF8000000 at latency 4; `busy` high for 5 cycles including DONE. With the macro: latency 1.
- sll b=0 (a=0x1234) → EXEC path, latency 1, result 0x1234; sll b=31, a=1 → latency 31, result 0x80000000.
- Backpressure: `out_ready`=0 for 3 cycles after `out_valid` → result stable, `in_ready`=0; drains on the first `out_ready`=1 cycle.
- `flush` on cycle 2 of a 10-step srl → IDLE next cycle, `out_valid` never asserts; a simultaneous `in_valid` is not accepted.

Source files
------------

// File: rtl/alu_seq_if.sv
// Bundles the ID/EX issue, ALU operand/result and EX/MEM result signals
// around the EX-stage ALU sequencer.
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_f7b5;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_f7b5, in_a, in_b,
        input  alu_result, out_ready,
        output in_ready, alu_sel, alu_a, alu_b, out_valid, out_result
    );

    modport master (
        output in_valid, in_opcode, in_funct3, in_f7b5, in_a, in_b,
        output alu_result, out_ready,
        input  in_ready, alu_sel, alu_a, alu_b, out_valid, out_result
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// EX-stage sequencer for the shared integer ALU; shifts loop shift-by-1 through the ALU.
// Define ALU_FAST_SHIFT_EN when the external ALU shifts by the full amount in one cycle.
module alu_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    output logic        busy,
    alu_seq_if.slave    bus
);
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_LUI  = 4'd2;
    localparam logic [3:0] SEL_AND  = 4'd3;
    localparam logic [3:0] SEL_XOR  = 4'd4;
    localparam logic [3:0] SEL_OR   = 4'd5;
    localparam logic [3:0] SEL_SLL  = 4'd6;
    localparam logic [3:0] SEL_SRL  = 4'd7;
    localparam logic [3:0] SEL_SRA  = 4'd8;
    localparam logic [3:0] SEL_SLT  = 4'd9;
    localparam logic [3:0] SEL_SLTU = 4'd10;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
`endif

    function automatic logic [3:0] decode(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       f7b5);
        logic [3:0] sel;
        sel = SEL_ADD;
        if (opcode == OPC_R || opcode == OPC_I) begin
            case (funct3)
                3'b000:  sel = (opcode == OPC_R && f7b5) ? SEL_SUB : SEL_ADD;
                3'b001:  sel = SEL_SLL;
                3'b010:  sel = SEL_SLT;
                3'b011:  sel = SEL_SLTU;
                3'b100:  sel = SEL_XOR;
                3'b101:  sel = f7b5 ? SEL_SRA : SEL_SRL;
                3'b110:  sel = SEL_OR;
                default: sel = SEL_AND;
            endcase
        end else if (opcode == OPC_LUI) begin
            sel = SEL_LUI;
        end
        return sel;
    endfunction

`ifndef ALU_FAST_SHIFT_EN
    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == SEL_SLL) || (sel == SEL_SRL) || (sel == SEL_SRA);
    endfunction
`endif

    state_t          state_q, state_d;
    logic [3:0]      op_q;
    logic [XLEN-1:0] p_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] out_result_q;
`ifndef ALU_FAST_SHIFT_EN
    logic [4:0]      cnt_q;
`endif
    logic [3:0]      dec_sel;
    logic            accept;
    logic [3:0]      alu_sel_c;
    logic [XLEN-1:0] alu_a_c, alu_b_c;

    assign dec_sel = decode(bus.in_opcode, bus.in_funct3, bus.in_f7b5);
    // flush wins over accept even though in_ready stays high in IDLE
    assign accept  = bus.in_valid && (state_q == IDLE) && !flush;

    always_comb begin
        state_d   = state_q;
        alu_sel_c = SEL_ADD;
        alu_a_c   = '0;
        alu_b_c   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_FAST_SHIFT_EN
                    state_d = EXEC;
`else
                    state_d = (is_shift(dec_sel) && bus.in_b[4:0] != 5'd0) ? SHIFT : EXEC;
`endif
                end
            end
            EXEC: begin
                alu_sel_c = op_q;
                alu_a_c   = p_q;
                alu_b_c   = b_q;
                state_d   = DONE;
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                alu_sel_c = op_q;
                alu_a_c   = p_q;
                alu_b_c   = XLEN'(1);
                if (cnt_q == 5'd1) state_d = DONE;
            end
`endif
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= SEL_ADD;
            p_q          <= '0;
            b_q          <= '0;
            out_result_q <= '0;
`ifndef ALU_FAST_SHIFT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= dec_sel;
                p_q  <= bus.in_a;
                b_q  <= bus.in_b;
`ifndef ALU_FAST_SHIFT_EN
                cnt_q <= bus.in_b[4:0];
`endif
            end
            // an aborted operation leaves the previous result in place
            if (!flush) begin
                if (state_q == EXEC) out_result_q <= bus.alu_result;
`ifndef ALU_FAST_SHIFT_EN
                if (state_q == SHIFT) begin
                    p_q   <= bus.alu_result;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) out_result_q <= bus.alu_result;
                end
`endif
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = out_result_q;
    assign bus.alu_sel    = alu_sel_c;
    assign bus.alu_a      = alu_a_c;
    assign bus.alu_b      = alu_b_c;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl with a behavioural ALU and an
// instruction-level reference model (honours ALU_FAST_SHIFT_EN).
module tb_alu_seq_ctrl;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] last_res;

    alu_seq_if #(.XLEN(32)) bus ();

    alu_seq_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (bus.alu_sel)
            4'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
            4'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
            4'd2:    bus.alu_result = bus.alu_b;
            4'd3:    bus.alu_result = bus.alu_a & bus.alu_b;
            4'd4:    bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'd5:    bus.alu_result = bus.alu_a | bus.alu_b;
            4'd6:    bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            4'd7:    bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            4'd8:    bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            4'd9:    bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'd10:   bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
            default: bus.alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic alu_class(input logic [6:0] op);
        return (op == OPC_R) || (op == OPC_I);
    endfunction

    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [2:0] f3,
                                               input logic f7, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if (op == OPC_LUI) return b;
        if (!alu_class(op)) return a + b;
        case (f3)
            3'd0:    return (op == OPC_R && f7) ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7 ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [3:0] ref_sel(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic [3:0] by_f3 [8];
        by_f3 = '{4'd0, 4'd6, 4'd9, 4'd10, 4'd4, 4'd7, 4'd5, 4'd3};
        if (op == OPC_LUI) return 4'd2;
        if (!alu_class(op)) return 4'd0;
        if (f3 == 3'd0 && op == OPC_R && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd8;
        return by_f3[f3];
    endfunction

    function automatic logic iterative(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1'b0;
`else
        return alu_class(op) && (f3 == 3'd1 || f3 == 3'd5) && (b[4:0] != 5'd0);
`endif
    endfunction

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_r;
        int exp_lat, lat, bcnt;
        logic it;
        exp_r   = ref_result(op, f3, f7, a, b);
        it      = iterative(op, f3, b);
        exp_lat = it ? int'(b[4:0]) : 1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_f7b5   = f7;
        bus.in_a      = a;
        bus.in_b      = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        check("alu_sel", {28'd0, bus.alu_sel}, {28'd0, ref_sel(op, f3, f7)});
        check("alu_a", bus.alu_a, a);
        check("alu_b", bus.alu_b, it ? 32'd1 : b);
        bcnt = int'(busy);
        lat  = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bcnt += int'(busy);
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", bus.out_result, exp_r);
        check("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bcnt += int'(busy);
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_result", bus.out_result, exp_r);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bcnt += int'(busy);
        check("drained", {31'd0, bus.out_valid}, 32'd0);
        check("busy_cycles", 32'(bcnt), 32'(exp_lat + 1 + hold));
        last_res = exp_r;
    endtask

    initial begin
        logic [6:0] other_ops [5];
        logic [6:0] op;
        int kind, ov;
        other_ops = '{7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0010111};
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_opcode = OPC_R; bus.in_funct3 = 3'd1; bus.in_f7b5 = 1'b0;
        bus.in_a = 32'h1; bus.in_b = 32'd9;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed cases
        run_op(OPC_R, 3'd0, 1'b1, 32'd5, 32'd7, 0);
        run_op(OPC_I, 3'd0, 1'b1, 32'd5, 32'd7, 0);
        run_op(OPC_I, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 0);
        run_op(OPC_I, 3'd1, 1'b0, 32'h1234, 32'd0, 0);
        run_op(OPC_R, 3'd1, 1'b0, 32'd1, 32'd31, 0);
        run_op(OPC_R, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 3);
        run_op(OPC_R, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 1);
        run_op(OPC_LUI, 3'd0, 1'b0, 32'h5555_5555, 32'hABCD_E000, 2);

        // Flush on cycle 2 of a 10-step srl, with a competing in_valid
        run_op(OPC_R, 3'd6, 1'b0, 32'h00F0_0000, 32'h0000_0F00, 0);
        bus.in_valid = 1'b1; bus.in_opcode = OPC_R; bus.in_funct3 = 3'd5; bus.in_f7b5 = 1'b0;
        bus.in_a = 32'hF0F0_F0F0; bus.in_b = 32'd10;
        @(posedge clk); #1;
        bus.in_opcode = OPC_R; bus.in_funct3 = 3'd0; bus.in_a = 32'd1; bus.in_b = 32'd2;
        @(posedge clk); #1;
`ifndef ALU_FAST_SHIFT_EN
        check("pre_flush_valid", {31'd0, bus.out_valid}, 32'd0);
`endif
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef ALU_FAST_SHIFT_EN
        check("flush_stale", bus.out_result, 32'hF0F0_F0F0 >> 10);
`else
        check("flush_stale", bus.out_result, last_res);
`endif
        ov = 0;
        repeat (12) begin
            @(posedge clk); #1;
            ov += int'(bus.out_valid) + int'(busy);
        end
        check("flush_quiet", 32'(ov), 32'd0);

        // Flush while idle blocks the accept
        bus.in_valid = 1'b1; bus.in_opcode = OPC_R; bus.in_funct3 = 3'd0; bus.in_a = 32'd3; bus.in_b = 32'd4;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a long shift
        bus.in_valid = 1'b1; bus.in_opcode = OPC_R; bus.in_funct3 = 3'd1; bus.in_f7b5 = 1'b0;
        bus.in_a = 32'h0000_0003; bus.in_b = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_out_result", bus.out_result, 32'd0);
        check("arst_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4)       op = OPC_R;
            else if (kind < 8)  op = OPC_I;
            else if (kind == 8) op = OPC_LUI;
            else                op = other_ops[$urandom_range(0, 4)];
            run_op(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
